// File: rtl/ifu_prefetch_if.sv
// Instruction-fetch bundle: ROM request/response, execute-stage redirect and decode-stage handoff.
// master = fetch unit (drives ROM request and decode outputs), slave = surrounding pipeline/ROM.
// ROM read latency is one cycle; decode backpressure is a plain valid/ready pair.
`ifndef ROM_DEPTH
`define ROM_DEPTH 256
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface ifu_prefetch_if;
   localparam int AW = $clog2(`ROM_DEPTH);
   localparam int DW = `DATA_WIDTH;

   logic [AW-1:0] rom_addr_o_ifu_rom;
   logic          rom_req_o_ifu_rom;
   logic [DW-1:0] rom_data_i_rom_ifu;
   logic          jump_en_i_exu_ifu;
   logic [AW-1:0] jump_addr_i_exu_ifu;
   logic          ready_i_idu_ifu;
   logic [DW-1:0] instr_o_ifu2idu_idu;
   logic [AW-1:0] instr_addr_o_ifu2idu_idu;
   logic          instr_valid_o_ifu_idu;

   modport master (
      output rom_addr_o_ifu_rom, rom_req_o_ifu_rom,
      output instr_o_ifu2idu_idu, instr_addr_o_ifu2idu_idu, instr_valid_o_ifu_idu,
      input  rom_data_i_rom_ifu, jump_en_i_exu_ifu, jump_addr_i_exu_ifu, ready_i_idu_ifu
   );

   modport slave (
      input  rom_addr_o_ifu_rom, rom_req_o_ifu_rom,
      input  instr_o_ifu2idu_idu, instr_addr_o_ifu2idu_idu, instr_valid_o_ifu_idu,
      output rom_data_i_rom_ifu, jump_en_i_exu_ifu, jump_addr_i_exu_ifu, ready_i_idu_ifu
   );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: fetch PC, one-cycle ROM, 2-entry {instr, addr} FIFO feeding decode.
// Latency: ROM request to decode output 2 cycles (1 cycle with IFU_BYPASS_EN defined).
// Backpressure: ready low holds the head stable; requests stop once FIFO + in-flight reach 2.
// Ports: clk, rst_n (async active-low), bus (ifu_prefetch_if.master: ROM, redirect, decode).
`ifndef ROM_DEPTH
`define ROM_DEPTH 256
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ifu_prefetch (
   input  logic          clk,
   input  logic          rst_n,
   ifu_prefetch_if.master bus
);
   localparam int AW = $clog2(`ROM_DEPTH);
   localparam int DW = `DATA_WIDTH;
   localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

   // architectural state
   logic [AW-1:0] pc;
   logic [DW-1:0] fifo_instr [2];
   logic [AW-1:0] fifo_addr  [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    count;
   logic          inflight;
   logic [AW-1:0] inflight_addr;

   // per-cycle decisions
   logic          jump;
   logic          fifo_empty;
   logic          bypass;
   logic          pop;
   logic          push;
   logic          req;
   logic [AW-1:0] req_addr;
   logic [2:0]    occupancy;
   logic          out_vld;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_addr;

   assign jump       = bus.jump_en_i_exu_ifu;
   assign fifo_empty = (count == 2'd0);

`ifdef IFU_BYPASS_EN
   // Response may go straight to decode when nothing older is queued.
   assign bypass = fifo_empty & inflight & ~jump;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      out_vld   = 1'b0;
      out_instr = NOP;
      out_addr  = '0;
      if (!fifo_empty) begin
         out_vld   = 1'b1;
         out_instr = fifo_instr[rd_ptr];
         out_addr  = fifo_addr[rd_ptr];
      end else if (bypass) begin
         out_vld   = 1'b1;
         out_instr = bus.rom_data_i_rom_ifu;
         out_addr  = inflight_addr;
      end
      // A redirect makes everything presented this cycle stale.
      if (jump) out_vld = 1'b0;
   end

   assign pop  = out_vld & bus.ready_i_idu_ifu;
   // A bypassed response that decode takes this cycle needs no storage.
   assign push = inflight & ~jump & ~(bypass & bus.ready_i_idu_ifu);

   // FIFO entries plus the response still in flight, minus what leaves now.
   // A pop always implies count or inflight is set, so this never underflows.
   assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign req       = rst_n & (jump | (occupancy < 3'd2));
   assign req_addr  = !rst_n ? '0 : (jump ? bus.jump_addr_i_exu_ifu : pc);

   assign bus.rom_req_o_ifu_rom        = req;
   assign bus.rom_addr_o_ifu_rom       = req_addr;
   assign bus.instr_valid_o_ifu_idu    = out_vld;
   assign bus.instr_o_ifu2idu_idu      = out_instr;
   assign bus.instr_addr_o_ifu2idu_idu = out_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= '0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= 2'd0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
      end else begin
         inflight <= req;
         if (req) begin
            inflight_addr <= req_addr;
            pc            <= req_addr + AW'(4);   // wraps modulo 2^AW
         end
         if (jump) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // Payload storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.rom_data_i_rom_ifu;
         fifo_addr[wr_ptr]  <= inflight_addr;
      end
   end
endmodule

// File: tb/tb_ifu_prefetch.sv
`ifndef ROM_DEPTH
`define ROM_DEPTH 256
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_ifu_prefetch;
   localparam int AW = $clog2(`ROM_DEPTH);
   localparam int DW = `DATA_WIDTH;
`ifdef IFU_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   localparam logic [AW-1:0] TOP_M8 = AW'((1 << AW) - 8);
   localparam logic [AW-1:0] TOP_M4 = AW'((1 << AW) - 4);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifu_prefetch_if bus();
   ifu_prefetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] instr;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_mis = 0;
   int            n_xfer = 0;
   logic          last_req;
   logic [AW-1:0] last_addr;
   logic          last_vld;
   logic [AW-1:0] last_oaddr;

   // ROM contents: word[i] = i
   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return DW'(a >> 2);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Program-order expectation from a start address (flushes anything older).
   task automatic expect_from(input logic [AW-1:0] start, input int n);
      logic [AW-1:0] a;
      sb.delete();
      for (int i = 0; i < n; i++) begin
         a = start + AW'(4 * i);
         sb.push_back({a, word(a)});
      end
   endtask

   // One clock: sample just after inputs settle, score any transfer, model the ROM.
   task automatic step();
      exp_t e;
      #1;
      last_req   = bus.rom_req_o_ifu_rom;
      last_addr  = bus.rom_addr_o_ifu_rom;
      last_vld   = bus.instr_valid_o_ifu_idu;
      last_oaddr = bus.instr_addr_o_ifu2idu_idu;
      if (bus.instr_valid_o_ifu_idu && bus.ready_i_idu_ifu) begin
         n_xfer++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL sb_underflow: observed transfer addr 0x%0h expected none", last_oaddr);
         end else begin
            e = sb.pop_front();
            chk("out_addr", 64'(bus.instr_addr_o_ifu2idu_idu), 64'(e.addr));
            chk("out_instr", 64'(bus.instr_o_ifu2idu_idu), 64'(e.instr));
         end
      end
      @(posedge clk);
      #1;
      bus.rom_data_i_rom_ifu = last_req ? word(last_addr) : DW'(32'hDEAD_BEEF);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   64'(bus.rom_req_o_ifu_rom), 64'(0));
      chk({tag, "_raddr"}, 64'(bus.rom_addr_o_ifu_rom), 64'(0));
      chk({tag, "_vld"},   64'(bus.instr_valid_o_ifu_idu), 64'(0));
      chk({tag, "_instr"}, 64'(bus.instr_o_ifu2idu_idu), 64'h13);
      chk({tag, "_iaddr"}, 64'(bus.instr_addr_o_ifu2idu_idu), 64'(0));
   endtask

   initial begin
      int   xfer0;
      logic found;

      rst_n = 1'b0;
      bus.ready_i_idu_ifu     = 1'b0;
      bus.jump_en_i_exu_ifu   = 1'b0;
      bus.jump_addr_i_exu_ifu = '0;
      bus.rom_data_i_rom_ifu  = '0;
      @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);

      // Streaming from reset: consecutive issues, fixed initial latency
      rst_n = 1'b1;
      bus.ready_i_idu_ifu = 1'b1;
      expect_from('0, 64);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("issue_req", 64'(last_req), 64'(1));
         chk("issue_addr", 64'(last_addr), 64'(4 * k));
         chk("stream_valid", 64'(last_vld), 64'(k >= LAT));
      end

      // Stall with address 8 at the head
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         #1;
         if (bus.instr_valid_o_ifu_idu && bus.instr_addr_o_ifu2idu_idu == AW'(8)) found = 1'b1;
         else step();
      end
      chk("find_addr8", 64'(found), 64'(1));
      bus.ready_i_idu_ifu = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_vld", 64'(last_vld), 64'(1));
         chk("hold_addr", 64'(last_oaddr), 64'(8));
      end
      #1;
      chk("stall_req", 64'(bus.rom_req_o_ifu_rom), 64'(0));
      bus.ready_i_idu_ifu = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("resume_vld", 64'(last_vld), 64'(1));
      end

      // Redirect while the FIFO is full
      bus.ready_i_idu_ifu = 1'b0;
      for (int i = 0; i < 3; i++) step();
      bus.jump_en_i_exu_ifu   = 1'b1;
      bus.jump_addr_i_exu_ifu = AW'(8'h40);
      bus.ready_i_idu_ifu     = 1'b1;
      #1;
      chk("jump_vld", 64'(bus.instr_valid_o_ifu_idu), 64'(0));
      chk("jump_req", 64'(bus.rom_req_o_ifu_rom), 64'(1));
      chk("jump_raddr", 64'(bus.rom_addr_o_ifu_rom), 64'h40);
      expect_from(AW'(8'h40), 64);
      xfer0 = n_xfer;
      step();
      bus.jump_en_i_exu_ifu = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("post_jump_xfers", 64'(n_xfer - xfer0), 64'(5 - LAT));

      // Fetch address wraps past the top of the ROM
      bus.jump_en_i_exu_ifu   = 1'b1;
      bus.jump_addr_i_exu_ifu = TOP_M8;
      expect_from(TOP_M8, 64);
      step();
      bus.jump_en_i_exu_ifu = 1'b0;
      step();
      chk("wrap_addr_top", 64'(last_addr), 64'(TOP_M4));
      step();
      chk("wrap_req", 64'(last_req), 64'(1));
      chk("wrap_addr_zero", 64'(last_addr), 64'(0));
      for (int i = 0; i < 4; i++) step();

      // Reset mid-stream with data buffered and a request in flight
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expect_from('0, 64);
      xfer0 = n_xfer;
      step();
      chk("rst_first_req", 64'(last_req), 64'(1));
      chk("rst_first_addr", 64'(last_addr), 64'(0));
      for (int i = 0; i < 6; i++) step();
      chk("rst_stream_xfers", 64'(n_xfer - xfer0), 64'(7 - LAT));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rom_addr_o_ifu_rom, output, $clog2(`ROM_DEPTH) (AW), byte fetch address to instruction ROM.
REQ-004 SHALL have port rom_req_o_ifu_rom, output, 1, ROM read request; data returns exactly one cycle later.
REQ-005 SHALL have port rom_data_i_rom_ifu, input, `DATA_WIDTH, ROM read data for the request issued in the previous cycle.
REQ-006 SHALL have port jump_en_i_exu_ifu, input, 1, redirect request from the execute stage.
REQ-007 SHALL have port jump_addr_i_exu_ifu, input, AW, redirect target.
REQ-008 SHALL have port ready_i_idu_ifu, input, 1, decode stage accepts the presented instruction.
REQ-009 SHALL have port instr_o_ifu2idu_idu, output, `DATA_WIDTH, instruction to decode.
REQ-010 SHALL have port instr_addr_o_ifu2idu_idu, output, AW, address of instr_o_ifu2idu_idu.
REQ-011 SHALL have port instr_valid_o_ifu_idu, output, 1, instr/addr outputs hold a valid fetched instruction.

Function
REQ-012 SHALL keep a fetch PC (AW bits), a 2-entry FIFO of {instr, addr}, and a 1-bit in-flight flag marking a request issued in the previous cycle.
REQ-013 SHALL treat a ROM response as present in a cycle iff the in-flight flag is 1 in that cycle.
REQ-014 SHALL assert rom_req_o_ifu_rom when jump_en_i_exu_ifu=1, or when FIFO count + in-flight - pop < 2, with pop = instr_valid_o_ifu_idu & ready_i_idu_ifu.
REQ-015 SHALL drive rom_addr_o_ifu_rom = jump_addr_i_exu_ifu when jump_en_i_exu_ifu=1, else PC; PC SHALL advance to issued address + 4 on each issued request, wrapping modulo 2^AW.
REQ-016 SHALL push a present response (rom_data_i_rom_ifu, its issue address) into the FIFO unless discarded by REQ-018 or bypassed by REQ-025.
REQ-017 SHALL present the FIFO head on instr/addr outputs with instr_valid_o_ifu_idu=1 when non-empty; when empty, instr_o_ifu2idu_idu = 32'h00000013 (NOP), address = 0, valid = 0.
REQ-018 On jump_en_i_exu_ifu=1: flush FIFO to empty, discard the response present that cycle, force valid=0 that cycle (no pop), issue request at jump_addr_i_exu_ifu, set PC = jump_addr + 4 -> first redirected instruction valid at output no earlier than next cycle.
REQ-019 Simultaneous push and pop SHALL keep count unchanged; push into full FIFO SHALL never occur (guaranteed by REQ-014).
REQ-020 Output SHALL hold instr/addr stable while valid=1 and ready=0.
REQ-021 Instructions SHALL reach decode in strict program order with no duplicates or drops except those flushed by a jump.

Reset
REQ-022 While rst_n=0: PC=0, FIFO empty, in-flight=0, rom_req_o_ifu_rom=0, rom_addr_o_ifu_rom=0, instr_valid_o_ifu_idu=0, instr_o_ifu2idu_idu=32'h00000013, instr_addr_o_ifu2idu_idu=0.
REQ-023 First cycle after rst_n rises SHALL issue a request at address 0.
REQ-024 Reset asserted mid-operation SHALL discard all FIFO and in-flight contents immediately.

Configuration
REQ-025 With IFU_BYPASS_EN defined: when FIFO empty, response present and no jump, the response SHALL appear on outputs combinationally that cycle with valid=1, and SHALL be pushed only if ready_i_idu_ifu=0; without IFU_BYPASS_EN, responses SHALL always be pushed and appear no earlier than the next cycle.

Verification
REQ-026 Reset release, ROM word[i]=i, ready=1 -> addresses 0,4,8,12 issued on consecutive cycles; decode sees 0,1,2,3 in order, one per cycle after initial latency (1 cycle with bypass, 2 without).
REQ-027 ready=0 for 5 cycles from addr 8 -> at most 2 buffered + 0 in-flight, rom_req deasserts, output holds addr 8; on ready=1 stream resumes 8,12,16 without gap or repeat.
REQ-028 jump_en=1, jump_addr=0x40 while FIFO holds 2 entries -> valid=0 that cycle, rom_addr=0x40; next outputs 0x40, 0x44; flushed entries never seen.
REQ-029 PC at 2^AW-4, ready=1 -> next request address 0 (wrap).
REQ-030 rst_n pulled low while FIFO full and request in flight -> outputs at reset values same cycle; after release first request at address 0.
